gold_fall_scheduler: RTL and testbench
======================================

Name: gold_fall_scheduler

Overview:
- Per-frame controller that decides which gold blocks may fall. It drives the can_fall input of every gold_block instance.
- Once per frame it scans all NUM_GOLD blocks and looks up the tunnel/dirt cell below each one through a shared map read port (req/ack).
- It caps how many blocks fall at the same time and commits all can_fall bits together in one cycle.
- Sits between the gold_block array and the dirt-map memory, which it shares with other readers through the handshake.

Parameters:
- NUM_GOLD, 8, number of gold_block instances served
- MAX_FALLING, 2, maximum number of golds in FALLING state at once
- BOARD_X, 11'd32, board top-left X in pixels
- BOARD_Y, 11'd160, board top-left Y in pixels
- ROWS, 10, board height in 32-px tiles
- COLS, 15, board width in 32-px tiles

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-high (asserted = 1; port name kept per codebase)
- startOfFrame  in  1  one-cycle pulse per frame
- gold_TLX  in  NUM_GOLD*11  packed top-left X per gold; gold i occupies bits [11i+10:11i]
- gold_TLY  in  NUM_GOLD*11  packed top-left Y per gold
- gold_state  in  NUM_GOLD*4  packed gold_state per gold
- map_req  out  1  map lookup request
- map_col  out  4  tile column of the lookup
- map_row  out  4  tile row of the lookup
- map_ack  in  1  lookup done; map_empty is valid in the same cycle
- map_empty  in  1  1 = tile is tunnel (no dirt)
- can_fall  out  NUM_GOLD  per-gold fall permission, registered
- scan_busy  out  1  high while a scan is in progress
- frame_overrun  out  1  sticky: startOfFrame arrived while busy

Behaviour:
- Reset (async, level): can_fall=0, map_req=0, map_col=0, map_row=0, scan_busy=0, frame_overrun=0. Start pointer and all FSM state return to IDLE/0. If reset is asserted mid-lookup, map_req drops immediately.
- Gold state codes: 0 IDLE, 1 WOBBLE, 2 FALLING, 3 EATEN.
- FSM states: IDLE, SNAP, EVAL, LOOKUP, APPLY.
- IDLE: on startOfFrame go to SNAP.
- SNAP (1 cycle):
  - Register all TLX/TLY/state inputs into a snapshot.
  - Shadow register <= current can_fall.
  - fall_cnt <= number of golds whose state is FALLING.
  - idx <= start_ptr; visited count <= 0.
- EVAL (1 cycle per gold), rules for gold idx, applied in this order:
  - EATEN -> shadow[idx]=0.
  - TLX<BOARD_X or TLY<BOARD_Y -> shadow=0.
  - col=(TLX-BOARD_X)>>5, row=((TLY-BOARD_Y)>>5)+1, using 11-bit subtraction. If col>=COLS or row>=ROWS -> shadow=0.
  - FALLING and TLY not tile-aligned (TLY-BOARD_Y)[4:0]!=0 -> shadow stays 1; no lookup.
  - Otherwise go to LOOKUP.
- LOOKUP:
  - Drive map_req=1 with col/row held stable until map_ack is sampled high. map_req goes low the next cycle.
  - map_ack while map_req=0 is ignored.
  - At ack, if map_empty=0 -> shadow=0, and if the gold was FALLING, decrement fall_cnt.
  - If map_empty=1 and the gold is already FALLING -> shadow=1.
  - If map_empty=1, gold not FALLING and fall_cnt<MAX_FALLING -> shadow=1 and fall_cnt++.
  - If map_empty=1, gold not FALLING and fall_cnt>=MAX_FALLING -> shadow=0 (denied this frame).
- After each gold: idx wraps modulo NUM_GOLD; visited++. When visited reaches NUM_GOLD go to APPLY, otherwise go to EVAL.
- APPLY (1 cycle): can_fall<=shadow (all bits commit in the same cycle), start_ptr<=start_ptr+1 (wraps), go to IDLE.
- scan_busy = (state != IDLE).
- startOfFrame while scan_busy: set frame_overrun; the pulse is otherwise ignored and the scan continues.
- Latency with zero-wait ack: startOfFrame to can_fall update ≤ 2 + 3*NUM_GOLD cycles. can_fall is constant between APPLY cycles.

Decomposition:
- Package gold_pkg holds:
  - gold_state_t enum (IDLE/WOBBLE/FALLING/EATEN = 0..3)
  - TILE_SHIFT=5
  - sched_state_t FSM enum
- One sub-module, gold_tile_calc: combinational TLX/TLY -> col/row/aligned/out_of_board. It is reused by the dirt-map writer.

Test Plan:
- Single gold at (BOARD_X+160, BOARD_Y+32), state IDLE, ack one cycle after req with map_empty=1 -> map_col=5, map_row=2 on the request; can_fall[0]=1 after APPLY; all other bits 0.
- Same gold, map_empty=0 -> can_fall[0]=0; exactly one map_req pulse; scan_busy low within 2+3*NUM_GOLD cycles.
- MAX_FALLING=2, golds 0..3 all IDLE with empty cells below, start_ptr=0 -> can_fall=4'b0011. Next frame (states unchanged) start_ptr=1 -> can_fall=4'b0110.
- Gold FALLING at TLY=BOARD_Y+40 (unaligned) -> no map_req issued for it; can_fall bit stays 1. Gold state EATEN -> bit cleared, no request.
- Hold map_ack low for 20 cycles and pulse startOfFrame -> map_req, map_col and map_row stable throughout; frame_overrun=1 and stays 1; scan completes normally once ack arrives.
- Assert resetN during LOOKUP -> map_req=0 and can_fall=0 in the same cycle; after release, the next startOfFrame starts a scan at idx 0.

Source files
------------

// File: rtl/gold_pkg.sv
// Shared types for the gold-block subsystem: gold state codes, tile geometry
// and the fall-scheduler FSM encoding.
package gold_pkg;

    typedef enum logic [3:0] {
        GOLD_IDLE    = 4'd0,
        GOLD_WOBBLE  = 4'd1,
        GOLD_FALLING = 4'd2,
        GOLD_EATEN   = 4'd3
    } gold_state_t;

    // Tiles are 32x32 pixels.
    localparam int TILE_SHIFT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_EVAL,
        S_LOOKUP,
        S_APPLY
    } sched_state_t;

endpackage

// File: rtl/gold_tile_calc.sv
// Pixel top-left to tile coordinate of the cell directly below a gold block.
// Shared with the dirt-map writer, so it stays purely combinational.
module gold_tile_calc
    import gold_pkg::*;
#(
    parameter logic [10:0] BOARD_X = 11'd32,
    parameter logic [10:0] BOARD_Y = 11'd160,
    parameter int          ROWS    = 10,
    parameter int          COLS    = 15
) (
    input  logic [10:0] tlx,
    input  logic [10:0] tly,
    output logic [3:0]  col,
    output logic [3:0]  row,
    output logic        aligned,
    output logic        out_of_board
);

    localparam logic [6:0] COLS_L = 7'(COLS);
    localparam logic [6:0] ROWS_L = 7'(ROWS);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [5:0]  col_full;
    logic [6:0]  row_full;

    always_comb begin
        dx       = tlx - BOARD_X;
        dy       = tly - BOARD_Y;
        col_full = 6'(dx >> TILE_SHIFT);
        // The cell of interest is the one beneath the block, hence +1.
        row_full = 7'(dy >> TILE_SHIFT) + 7'd1;
        aligned  = (dy[TILE_SHIFT-1:0] == '0);
        out_of_board = (tlx < BOARD_X) || (tly < BOARD_Y) ||
                       ({1'b0, col_full} >= COLS_L) || (row_full >= ROWS_L);
        col = col_full[3:0];
        row = row_full[3:0];
    end

endmodule

// File: rtl/gold_fall_scheduler.sv
// Once-per-frame scan of all gold blocks deciding which may fall, limited to
// MAX_FALLING simultaneous fallers; all can_fall bits change together.
module gold_fall_scheduler
    import gold_pkg::*;
#(
    parameter int          NUM_GOLD    = 8,
    parameter int          MAX_FALLING = 2,
    parameter logic [10:0] BOARD_X     = 11'd32,
    parameter logic [10:0] BOARD_Y     = 11'd160,
    parameter int          ROWS        = 10,
    parameter int          COLS        = 15
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [NUM_GOLD*11-1:0] gold_TLX,
    input  logic [NUM_GOLD*11-1:0] gold_TLY,
    input  logic [NUM_GOLD*4-1:0]  gold_state,
    output logic                  map_req,
    output logic [3:0]            map_col,
    output logic [3:0]            map_row,
    input  logic                  map_ack,
    input  logic                  map_empty,
    output logic [NUM_GOLD-1:0]   can_fall,
    output logic                  scan_busy,
    output logic                  frame_overrun
);

    localparam int IDX_W = (NUM_GOLD > 1) ? $clog2(NUM_GOLD) : 1;
    localparam int CNT_W = $clog2(NUM_GOLD + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_GOLD - 1);
    localparam logic [CNT_W-1:0] LAST_VISIT = CNT_W'(NUM_GOLD - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_FALLING);

    sched_state_t        state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    start_ptr;
    logic [IDX_W-1:0]    next_idx;
    logic [CNT_W-1:0]    visited;
    logic [CNT_W-1:0]    fall_cnt;
    logic [CNT_W-1:0]    falling_now;
    logic [NUM_GOLD-1:0] shadow;
    sched_state_t        after_gold;

    logic [10:0] snap_tlx [NUM_GOLD];
    logic [10:0] snap_tly [NUM_GOLD];
    logic [3:0]  snap_st  [NUM_GOLD];

    logic [3:0] cur_col;
    logic [3:0] cur_row;
    logic       cur_aligned;
    logic       cur_oob;
    logic       cur_falling;
    logic       cur_eaten;

    gold_tile_calc #(
        .BOARD_X (BOARD_X),
        .BOARD_Y (BOARD_Y),
        .ROWS    (ROWS),
        .COLS    (COLS)
    ) u_tile (
        .tlx          (snap_tlx[idx]),
        .tly          (snap_tly[idx]),
        .col          (cur_col),
        .row          (cur_row),
        .aligned      (cur_aligned),
        .out_of_board (cur_oob)
    );

    always_comb begin
        falling_now = '0;
        for (int i = 0; i < NUM_GOLD; i++) begin
            if (gold_state[4*i +: 4] == GOLD_FALLING) falling_now = falling_now + 1'b1;
        end
    end

    always_comb begin
        cur_falling = (snap_st[idx] == GOLD_FALLING);
        cur_eaten   = (snap_st[idx] == GOLD_EATEN);
        next_idx    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        after_gold  = (visited == LAST_VISIT) ? S_APPLY : S_EVAL;
    end

    assign scan_busy = (state != S_IDLE);

    // Map port handshake: map_req rises with map_col/map_row and all three hold
    // until a cycle in which map_ack is high (map_empty valid that same cycle);
    // map_req drops on the following edge. map_ack with map_req low is ignored.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state         <= S_IDLE;
            idx           <= '0;
            start_ptr     <= '0;
            visited       <= '0;
            fall_cnt      <= '0;
            shadow        <= '0;
            can_fall      <= '0;
            map_req       <= 1'b0;
            map_col       <= '0;
            map_row       <= '0;
            frame_overrun <= 1'b0;
            for (int i = 0; i < NUM_GOLD; i++) begin
                snap_tlx[i] <= '0;
                snap_tly[i] <= '0;
                snap_st[i]  <= '0;
            end
        end else begin
            if (startOfFrame && state != S_IDLE) frame_overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (startOfFrame) state <= S_SNAP;
                end

                S_SNAP: begin
                    for (int i = 0; i < NUM_GOLD; i++) begin
                        snap_tlx[i] <= gold_TLX[11*i +: 11];
                        snap_tly[i] <= gold_TLY[11*i +: 11];
                        snap_st[i]  <= gold_state[4*i +: 4];
                    end
                    shadow   <= can_fall;
                    fall_cnt <= falling_now;
                    idx      <= start_ptr;
                    visited  <= '0;
                    state    <= S_EVAL;
                end

                S_EVAL: begin
                    if (cur_eaten || cur_oob) begin
                        shadow[idx] <= 1'b0;
                        idx         <= next_idx;
                        visited     <= visited + 1'b1;
                        state       <= after_gold;
                    end else if (cur_falling && !cur_aligned) begin
                        // Mid-tile fallers keep going without consulting the map.
                        shadow[idx] <= 1'b1;
                        idx         <= next_idx;
                        visited     <= visited + 1'b1;
                        state       <= after_gold;
                    end else begin
                        map_req <= 1'b1;
                        map_col <= cur_col;
                        map_row <= cur_row;
                        state   <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (map_ack) begin
                        map_req <= 1'b0;
                        if (!map_empty) begin
                            shadow[idx] <= 1'b0;
                            if (cur_falling) fall_cnt <= fall_cnt - 1'b1;
                        end else if (cur_falling) begin
                            shadow[idx] <= 1'b1;
                        end else if (fall_cnt < MAX_CNT) begin
                            shadow[idx] <= 1'b1;
                            fall_cnt    <= fall_cnt + 1'b1;
                        end else begin
                            shadow[idx] <= 1'b0;
                        end
                        idx     <= next_idx;
                        visited <= visited + 1'b1;
                        state   <= after_gold;
                    end
                end

                S_APPLY: begin
                    can_fall  <= shadow;
                    start_ptr <= (start_ptr == LAST_IDX) ? '0 : start_ptr + 1'b1;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gold_fall_scheduler.sv
// Scoreboarded bench for gold_fall_scheduler: a map-port responder checks each
// lookup against queued expectations and every committed can_fall vector.
module tb_gold_fall_scheduler;
    import gold_pkg::*;

    localparam int          NUM_GOLD    = 8;
    localparam int          MAX_FALLING = 2;
    localparam logic [10:0] BOARD_X     = 11'd32;
    localparam logic [10:0] BOARD_Y     = 11'd160;
    localparam int          ROWS        = 10;
    localparam int          COLS        = 15;
    localparam int          LAT_MAX     = 2 + 3 * NUM_GOLD;
    localparam int          TIMEOUT     = 400;

    logic                    clk;
    logic                    resetN;
    logic                    startOfFrame;
    logic [NUM_GOLD*11-1:0]  gold_TLX;
    logic [NUM_GOLD*11-1:0]  gold_TLY;
    logic [NUM_GOLD*4-1:0]   gold_state;
    logic                    map_req;
    logic [3:0]              map_col;
    logic [3:0]              map_row;
    logic                    map_ack;
    logic                    map_empty;
    logic [NUM_GOLD-1:0]     can_fall;
    logic                    scan_busy;
    logic                    frame_overrun;

    logic [10:0] tlx [NUM_GOLD];
    logic [10:0] tly [NUM_GOLD];
    logic [3:0]  gst [NUM_GOLD];
    bit          tile_empty [16][16];

    logic [7:0]          exp_req_q[$];
    logic [NUM_GOLD-1:0] exp_cf_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    gold_fall_scheduler #(
        .NUM_GOLD    (NUM_GOLD),
        .MAX_FALLING (MAX_FALLING),
        .BOARD_X     (BOARD_X),
        .BOARD_Y     (BOARD_Y),
        .ROWS        (ROWS),
        .COLS        (COLS)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .gold_TLX      (gold_TLX),
        .gold_TLY      (gold_TLY),
        .gold_state    (gold_state),
        .map_req       (map_req),
        .map_col       (map_col),
        .map_row       (map_row),
        .map_ack       (map_ack),
        .map_empty     (map_empty),
        .can_fall      (can_fall),
        .scan_busy     (scan_busy),
        .frame_overrun (frame_overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_GOLD; i++) begin
            gold_TLX[11*i +: 11] = tlx[i];
            gold_TLY[11*i +: 11] = tly[i];
            gold_state[4*i +: 4] = gst[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver tasks
    task automatic apply_reset();
        resetN = 1'b1;
        startOfFrame = 1'b0;
        map_ack = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
    endtask

    task automatic park_all();
        for (int i = 0; i < NUM_GOLD; i++) begin
            tlx[i] = BOARD_X;
            tly[i] = BOARD_Y;
            gst[i] = GOLD_EATEN;
        end
    endtask

    task automatic fill_tiles(input bit v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tile_empty[r][c] = v;
    endtask

    task automatic set_gold(input int i, input int x, input int y, input gold_state_t s);
        tlx[i] = 11'(x);
        tly[i] = 11'(y);
        gst[i] = s;
    endtask

    // Pulses startOfFrame, services lookups and checks the committed result.
    // Called right after a negedge.
    task automatic run_frame(input string tag, input int ack_delay, input int overrun_at,
                             input bit chk_lat);
        int lat;
        int wait_cnt;
        int req_pulses;
        int exp_pulses;
        int unstable;
        bit prev_req;
        bit done;
        logic [7:0] held;
        logic [7:0] exp_req;
        logic [NUM_GOLD-1:0] exp_cf;
        lat = 0; wait_cnt = 0; req_pulses = 0; unstable = 0;
        prev_req = 1'b0; done = 1'b0; held = '0;
        exp_pulses = exp_req_q.size();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            map_ack = 1'b0;
            map_empty = 1'b0;
            if (!scan_busy) begin
                done = 1'b1;
            end else begin
                if (map_req) begin
                    if (!prev_req) begin
                        req_pulses++;
                        held = {map_col, map_row};
                        wait_cnt = 0;
                        if (exp_req_q.size() > 0) begin
                            exp_req = exp_req_q.pop_front();
                            check({tag, "_req_colrow"}, 32'(held), 32'(exp_req));
                        end
                    end else if ({map_col, map_row} != held) begin
                        unstable++;
                    end
                    if (wait_cnt >= ack_delay) begin
                        map_ack = 1'b1;
                        map_empty = tile_empty[map_row][map_col];
                    end
                    wait_cnt++;
                end
                prev_req = map_req;
                startOfFrame = (lat == overrun_at);
                @(negedge clk);
                lat++;
            end
        end
        map_ack = 1'b0;
        startOfFrame = 1'b0;
        exp_cf = exp_cf_q.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_can_fall"}, 32'(can_fall), 32'(exp_cf));
        check({tag, "_req_pulses"}, 32'(req_pulses), 32'(exp_pulses));
        check({tag, "_req_stable"}, 32'(unstable), 32'd0);
        if (chk_lat) check({tag, "_latency_ok"}, 32'(lat <= LAT_MAX), 32'd1);
        exp_req_q.delete();
    endtask

    task automatic setup_four_idle();
        park_all();
        fill_tiles(1'b1);
        for (int i = 0; i < 4; i++)
            set_gold(i, BOARD_X + 32 * i, BOARD_Y, GOLD_IDLE);
    endtask

    initial begin
        bit seen;
        resetN = 1'b1;
        startOfFrame = 1'b0;
        map_ack = 1'b0;
        map_empty = 1'b0;
        park_all();
        fill_tiles(1'b1);
        repeat (3) @(negedge clk);

        // reset values
        check("rst_can_fall", 32'(can_fall), 32'd0);
        check("rst_map_req", 32'(map_req), 32'd0);
        check("rst_map_col", 32'(map_col), 32'd0);
        check("rst_map_row", 32'(map_row), 32'd0);
        check("rst_scan_busy", 32'(scan_busy), 32'd0);
        check("rst_overrun", 32'(frame_overrun), 32'd0);
        resetN = 1'b0;
        @(negedge clk);

        // single gold over an empty tile at col 5 row 2
        set_gold(0, BOARD_X + 160, BOARD_Y + 32, GOLD_IDLE);
        exp_req_q.push_back({4'd5, 4'd2});
        exp_cf_q.push_back(8'h01);
        run_frame("single_empty", 0, -1, 1'b1);

        // same gold, dirt below
        tile_empty[2][5] = 1'b0;
        exp_req_q.push_back({4'd5, 4'd2});
        exp_cf_q.push_back(8'h00);
        run_frame("single_dirt", 0, -1, 1'b1);

        // fall cap with rotating start pointer
        apply_reset();
        setup_four_idle();
        for (int i = 0; i < 4; i++) exp_req_q.push_back({4'(i), 4'd1});
        exp_cf_q.push_back(8'h03);
        run_frame("cap_ptr0", $urandom_range(0, 2), -1, 1'b0);
        for (int i = 1; i < 4; i++) exp_req_q.push_back({4'(i), 4'd1});
        exp_req_q.push_back({4'd0, 4'd1});
        exp_cf_q.push_back(8'h06);
        run_frame("cap_ptr1", $urandom_range(0, 2), -1, 1'b0);

        // unaligned faller, eaten, off-board, faller landing on dirt
        apply_reset();
        park_all();
        fill_tiles(1'b1);
        tile_empty[1][1] = 1'b0;
        set_gold(0, BOARD_X, BOARD_Y + 40, GOLD_FALLING);
        set_gold(1, BOARD_X + 32, BOARD_Y, GOLD_FALLING);
        set_gold(2, BOARD_X + 64, BOARD_Y, GOLD_EATEN);
        set_gold(3, BOARD_X + 96, BOARD_Y, GOLD_IDLE);
        set_gold(4, BOARD_X + 128, BOARD_Y, GOLD_IDLE);
        set_gold(5, 0, BOARD_Y, GOLD_IDLE);
        set_gold(6, BOARD_X, BOARD_Y + 32 * 9, GOLD_IDLE);
        set_gold(7, BOARD_X + 32 * 15, BOARD_Y, GOLD_WOBBLE);
        exp_req_q.push_back({4'd1, 4'd1});
        exp_req_q.push_back({4'd3, 4'd1});
        exp_req_q.push_back({4'd4, 4'd1});
        exp_cf_q.push_back(8'h09);
        run_frame("mixed", 0, -1, 1'b1);

        // slow ack with overrun pulse (start pointer now 1)
        park_all();
        fill_tiles(1'b1);
        set_gold(0, BOARD_X + 160, BOARD_Y + 32, GOLD_IDLE);
        check("overrun_clear_before", 32'(frame_overrun), 32'd0);
        exp_req_q.push_back({4'd5, 4'd2});
        exp_cf_q.push_back(8'h01);
        run_frame("slow_ack", 20, 5, 1'b0);
        check("overrun_set", 32'(frame_overrun), 32'd1);
        exp_req_q.push_back({4'd5, 4'd2});
        exp_cf_q.push_back(8'h01);
        run_frame("after_overrun", 0, -1, 1'b1);
        check("overrun_sticky", 32'(frame_overrun), 32'd1);

        // reset in the middle of a lookup
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (map_req) seen = 1'b1;
            else @(negedge clk);
        end
        check("midlookup_req_seen", 32'(seen), 32'd1);
        resetN = 1'b1;
        #1;
        check("midlookup_rst_req", 32'(map_req), 32'd0);
        check("midlookup_rst_can_fall", 32'(can_fall), 32'd0);
        check("midlookup_rst_busy", 32'(scan_busy), 32'd0);
        check("midlookup_rst_overrun", 32'(frame_overrun), 32'd0);
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        setup_four_idle();
        for (int i = 0; i < 4; i++) exp_req_q.push_back({4'(i), 4'd1});
        exp_cf_q.push_back(8'h03);
        run_frame("post_reset_ptr0", 0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
